wb_arbiter: RTL

- Writeback stage directly upstream of the register file; owns the file's single write port (address, data, write enable).
- Merges two producers into one write per cycle:
  - single-cycle ALU results;
  - variable-latency load returns, buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding loads and flags read-after-load hazards to decode.

---
 rtl/wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered load returns
// onto the register-file write port and tracks outstanding loads per register.
// Optional feature macro: STARVE_GUARD_EN (forces a FIFO drain whenever the FIFO is full).
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [ADDR_WIDTH-1:0]         alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [ADDR_WIDTH-1:0]         ld_rd,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    input  logic                          iss_valid,
    input  logic [ADDR_WIDTH-1:0]         iss_rd,
    input  logic [ADDR_WIDTH-1:0]         chk_rs1,
    input  logic [ADDR_WIDTH-1:0]         chk_rs2,
    output logic                          hazard,
    output logic                          alu_hold,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [NREG-1:0]       busy;
    logic                  out_is_ld;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  sel_alu;
    logic                  commit_ld;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign ld_ready   = !fifo_full;
    assign fifo_count = count;

`ifdef STARVE_GUARD_EN
    // A full FIFO takes the port for one cycle; the ALU producer re-presents its result.
    assign alu_hold = fifo_full;
`else
    assign alu_hold = 1'b0;
`endif

    assign sel_alu   = alu_valid && !alu_hold;
    assign pop       = !sel_alu && !fifo_empty;
    assign push      = ld_valid && ld_ready;
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign commit_ld = rf_we && out_is_ld;

    // Load-return FIFO: control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= ld_rd;
            data_mem[wr_ptr] <= ld_data;
        end
    end

    // Output register: one write per cycle; x0 destinations load but do not write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            out_is_ld <= 1'b0;
        end else if (sel_alu) begin
            rf_we     <= (alu_rd != '0);
            rf_addr   <= alu_rd;
            rf_data   <= alu_data;
            out_is_ld <= 1'b0;
        end else if (pop) begin
            rf_we     <= (head_rd != '0);
            rf_addr   <= head_rd;
            rf_data   <= head_data;
            out_is_ld <= 1'b1;
        end else begin
            rf_we     <= 1'b0;
            out_is_ld <= 1'b0;
        end
    end

    // Scoreboard: a new issue overrides a commit to the same register on one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (iss_valid && iss_rd == ADDR_WIDTH'(r))
                    busy[r] <= 1'b1;
                else if (commit_ld && rf_addr == ADDR_WIDTH'(r))
                    busy[r] <= 1'b0;
            end
        end
    end

    assign hazard = (busy[chk_rs1] && chk_rs1 != '0) ||
                    (busy[chk_rs2] && chk_rs2 != '0);

endmodule
